// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: keypad matrix lines and the debounced key report
interface keypad_scanner_if;
   logic [3:0] row_in;
   logic [3:0] col_out;
   logic [3:0] columns;
   logic [3:0] rows;
   logic       key_valid;
   logic       key_held;
   modport master (input row_in, output col_out, columns, rows, key_valid, key_held);
   modport slave  (output row_in, input col_out, columns, rows, key_valid, key_held);
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad column scan with per-sweep debounce
module keypad_scanner #(
   parameter int SCAN_DIV     = 1000,
   parameter int DEBOUNCE_CNT = 8
) (
   input logic              clk,
   input logic              reset,
   keypad_scanner_if.master kp
);
   localparam int DW = $clog2(SCAN_DIV);
   localparam int CW = $clog2(DEBOUNCE_CNT + 1);

   typedef enum logic [1:0] {RELEASED, PRESS_DB, PRESSED, RELEASE_DB} state_t;

   state_t        state;
   logic [3:0]    sync1, sync2;
   logic [DW-1:0] dwell;
   logic [1:0]    ptr;
   logic [2:0]    acc_col, acc_row, cand_col, cand_row;
   logic [2:0]    base_col, base_row, fin_col, fin_row, low_row;
   logic [CW-1:0] cnt;
   logic          sample, sweep_end, fin_none, match, cnt_done;

   assign sample    = dwell == DW'(SCAN_DIV - 1);
   assign sweep_end = sample && ptr == 2'd3;
   assign low_row   = !sync2[0] ? 3'd1 : !sync2[1] ? 3'd2 : !sync2[2] ? 3'd3 : !sync2[3] ? 3'd4 : 3'd0;
   assign base_col  = ptr == 2'd0 ? 3'd0 : acc_col;
   assign base_row  = ptr == 2'd0 ? 3'd0 : acc_row;
   assign fin_col   = base_col == 3'd0 && low_row != 3'd0 ? {1'b0, ptr} + 3'd1 : base_col;
   assign fin_row   = base_col == 3'd0 ? low_row : base_row;
   assign fin_none  = fin_col == 3'd0;
   assign match     = fin_col == cand_col && fin_row == cand_row;
   assign cnt_done  = cnt == CW'(DEBOUNCE_CNT - 1);

   // two-flop synchronizer on the raw row lines, idle high
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         sync1 <= 4'hF;
         sync2 <= 4'hF;
      end else begin
         sync1 <= kp.row_in;
         sync2 <= sync1;
      end

   // dwell counter and column pointer; column drive rotates with the pointer
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         dwell      <= '0;
         ptr        <= '0;
         kp.col_out <= 4'b1110;
      end else if (sample) begin
         dwell      <= '0;
         ptr        <= ptr + 2'd1;
         kp.col_out <= {kp.col_out[2:0], kp.col_out[3]};
      end else begin
         dwell      <= dwell + 1'b1;
      end

   // keep the first low row found so far in this sweep (column 1 starts afresh)
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         acc_col <= '0;
         acc_row <= '0;
      end else if (sample) begin
         acc_col <= fin_col;
         acc_row <= fin_row;
      end

   // once per sweep, debounce the final candidate and update the key report
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state        <= RELEASED;
         cnt          <= '0;
         cand_col     <= '0;
         cand_row     <= '0;
         kp.columns   <= '0;
         kp.rows      <= '0;
         kp.key_valid <= 1'b0;
         kp.key_held  <= 1'b0;
      end else begin
         kp.key_valid <= 1'b0;
         if (sweep_end)
            case (state)
               RELEASED:
                  if (!fin_none) begin
                     state    <= PRESS_DB;
                     cand_col <= fin_col;
                     cand_row <= fin_row;
                     cnt      <= CW'(1);
                  end
               PRESS_DB:
                  if (fin_none) begin
                     state <= RELEASED;
                     cnt   <= '0;
                  end else if (!match) begin
                     cand_col <= fin_col;
                     cand_row <= fin_row;
                     cnt      <= CW'(1);
                  end else if (cnt_done) begin
                     state        <= PRESSED;
                     cnt          <= '0;
                     kp.columns   <= {1'b0, cand_col};
                     kp.rows      <= {1'b0, cand_row};
                     kp.key_valid <= 1'b1;
                     kp.key_held  <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               PRESSED:
                  if (fin_none) begin
                     state <= RELEASE_DB;
                     cnt   <= CW'(1);
                  end
               RELEASE_DB:
                  if (!fin_none) begin
                     state <= PRESSED;
                     cnt   <= '0;
                  end else if (cnt_done) begin
                     state       <= RELEASED;
                     cnt         <= '0;
                     kp.columns  <= '0;
                     kp.rows     <= '0;
                     kp.key_held <= 1'b0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               default: state <= RELEASED;
            endcase
      end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed keypad scenarios with a behavioural matrix model
module tb_keypad_scanner;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] pk = '0;
   logic [3:0]  row_drv;
   int          checks = 0;
   int          errors = 0;
   int          pulses = 0;

   keypad_scanner_if kp ();

   keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (.clk(clk), .reset(reset), .kp(kp));

   always #5 clk = ~clk;

   // matrix model: row r pulled low while its column is driven and key (c,r) is down
   always_comb begin
      row_drv = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (!kp.col_out[c] && pk[c*4+r]) row_drv[r] = 1'b0;
   end
   assign kp.row_in = row_drv;

   function automatic logic [15:0] key(input int c, input int r);
      key = 16'd1 << ((c - 1) * 4 + (r - 1));
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // advance n falling edges, counting key_valid pulses seen
   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         if (kp.key_valid) pulses++;
      end
   endtask

   // hold reset two cycles, release on a falling edge so the next rising edge is sweep edge 1
   task automatic do_reset();
      reset = 1'b0;
      tick(2);
      reset = 1'b1;
      pulses = 0;
   endtask

   initial begin
      tick(2);
      chk("rst_col_out", kp.col_out, 4'b1110);
      chk("rst_columns", kp.columns, 0);
      chk("rst_rows", kp.rows, 0);
      chk("rst_valid", kp.key_valid, 0);
      chk("rst_held", kp.key_held, 0);
      reset = 1'b1;
      tick(4);  chk("rot_col2", kp.col_out, 4'b1101);
      tick(4);  chk("rot_col3", kp.col_out, 4'b1011);
      tick(4);  chk("rot_col4", kp.col_out, 4'b0111);
      tick(4);  chk("rot_wrap", kp.col_out, 4'b1110);

      do_reset();
      pk = key(2, 3);
      tick(47);
      chk("sp_early_valid", kp.key_valid, 0);
      chk("sp_early_held", kp.key_held, 0);
      tick(1);
      chk("sp_valid", kp.key_valid, 1);
      chk("sp_columns", kp.columns, 2);
      chk("sp_rows", kp.rows, 3);
      chk("sp_held", kp.key_held, 1);
      tick(1);
      chk("sp_valid_one_cycle", kp.key_valid, 0);
      tick(64);
      chk("sp_no_repeat", pulses, 1);
      chk("sp_still_held", kp.key_held, 1);

      do_reset();
      pk = key(4, 1);
      tick(32);
      pk = '0;
      tick(16);
      pk = key(4, 1);
      tick(32);
      chk("bounce_no_pulse", pulses, 0);
      chk("bounce_not_held", kp.key_held, 0);
      tick(16);
      chk("bounce_pulse", pulses, 1);
      chk("bounce_columns", kp.columns, 4);
      chk("bounce_rows", kp.rows, 1);

      do_reset();
      pk = key(3, 1) | key(1, 4);
      tick(48);
      chk("simul_pulse", pulses, 1);
      chk("simul_columns", kp.columns, 1);
      chk("simul_rows", kp.rows, 4);

      do_reset();
      pk = key(2, 2);
      tick(48);
      chk("glitch_pulse", pulses, 1);
      pk = '0;
      tick(32);
      chk("glitch_held_mid", kp.key_held, 1);
      chk("glitch_columns_mid", kp.columns, 2);
      pk = key(2, 2);
      tick(16);
      chk("glitch_no_second", pulses, 1);
      chk("glitch_held_back", kp.key_held, 1);
      pk = '0;
      tick(47);
      chk("release_early_held", kp.key_held, 1);
      tick(1);
      chk("release_held", kp.key_held, 0);
      chk("release_columns", kp.columns, 0);
      chk("release_rows", kp.rows, 0);
      chk("release_no_pulse", pulses, 1);

      do_reset();
      pk = key(3, 2);
      tick(37);
      chk("mid_pre_col_out", kp.col_out, 4'b1101);
      reset = 1'b0;
      #1;
      chk("mid_async_col_out", kp.col_out, 4'b1110);
      do_reset();
      tick(47);
      chk("mid_db_no_early", pulses, 0);
      tick(1);
      chk("mid_db_pulse", pulses, 1);
      chk("mid_db_columns", kp.columns, 3);
      chk("mid_db_rows", kp.rows, 2);
      tick(5);
      reset = 1'b0;
      #1;
      chk("mid_pr_columns", kp.columns, 0);
      chk("mid_pr_rows", kp.rows, 0);
      chk("mid_pr_held", kp.key_held, 0);
      chk("mid_pr_col_out", kp.col_out, 4'b1110);
      do_reset();
      tick(47);
      chk("mid_pr_no_early", pulses, 0);
      tick(1);
      chk("mid_pr_pulse", pulses, 1);
      chk("mid_pr_columns2", kp.columns, 3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
